maxpool2_stage: RTL and testbench
=================================

Name: maxpool2_stage

Overview:
- Downstream neighbour of the convolution stage. Consumes one finished, ReLU'd output map at a time from the conv stage's ping-pong output memory.
- Performs 2x2, stride-2 max pooling and writes the pooled map into its own ping-pong output memory for the following layer.
- Handshakes upstream with start_from_previous/end_to_previous and downstream with start_to_next/end_from_next, using the same protocol the conv stage uses.

Parameters:
- DATA_WIDTH, 32, element width. Inputs are post-ReLU and non-negative, so an unsigned compare is exact for both fixed-point and IEEE-754.
- IFM_SIZE, 9, input map side length.
- NUMBER_OF_FILTERS, 28, maps per layer; used by the map counter.
- OFM_SIZE, IFM_SIZE/2 (floor), output side length. With odd IFM_SIZE the last row and column are dropped.
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), read address width.
- ADDRESS_SIZE_OFM, $clog2(OFM_SIZE*OFM_SIZE), write address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start_from_previous  in  1  one-cycle pulse: upstream map ready
- end_to_previous  out  1  high when this stage can accept a start
- ifm_sel_previous  out  1  upstream bank being read
- ifm_enable_read  out  1  read strobe to upstream memory
- ifm_address_read  out  ADDRESS_SIZE_IFM  read address
- ifm_data_in  in  DATA_WIDTH  read data, valid 1 cycle after strobe
- ofm_enable_write  out  1  write strobe to own output memory
- ofm_address_write  out  ADDRESS_SIZE_OFM  write address
- ofm_data_out  out  DATA_WIDTH  pooled value
- ifm_sel_next  out  1  bank being written
- end_from_next  in  1  downstream can accept a map
- start_to_next  out  1  one-cycle pulse: map handed downstream
- map_count  out  $clog2(NUMBER_OF_FILTERS)  maps completed, wraps at NUMBER_OF_FILTERS

Behaviour:
- Reset: all outputs 0 except end_to_previous, which is 1. FSM goes to IDLE; all counters, max register and out_full clear. Reset mid-map discards the partial map and performs no write.
- FSM states are IDLE, READ, DRAIN and WAIT_NEXT.
- IDLE:
  - end_to_previous = ~out_full.
  - start_from_previous is accepted only when end_to_previous = 1; otherwise it is ignored.
  - On accept: next state READ, ifm_sel_previous toggles, window counters clear.
- READ:
  - ifm_enable_read = 1 every cycle; end_to_previous = 0.
  - Read k (k = 0..4*OFM_SIZE^2-1) belongs to window w = k/4, with row r = w/OFM_SIZE and column c = w%OFM_SIZE.
  - Sub-index j = k%4 selects the address: j=0 → 2r*IFM_SIZE+2c; j=1 → +1; j=2 → +IFM_SIZE; j=3 → +IFM_SIZE+1.
  - After the last read, go to DRAIN.
- Datapath:
  - A valid flag and sub-index are delayed 1 cycle alongside the read.
  - When the delayed j = 0, the max register loads ifm_data_in. When delayed j = 1..3, it loads ifm_data_in only if ifm_data_in > max (unsigned); on equality it keeps its value.
  - The cycle after delayed j = 3: ofm_enable_write = 1, ofm_data_out = max, ofm_address_write = w.
- Latency: start accepted at edge 0; read k issues in cycle 1+k; write w occurs in cycle 6+4w. With defaults, 16 writes, the last in cycle 66.
- DRAIN:
  - Waits for the final write. That cycle sets out_full, increments map_count (wraps to 0 after NUMBER_OF_FILTERS-1), and moves to WAIT_NEXT.
- WAIT_NEXT:
  - Always returns to IDLE on the next cycle; out_full remains the hold flag.
- Downstream handshake, independent of the FSM:
  - While out_full = 1 and end_from_next = 1: start_to_next = 1 (combinational) for exactly that cycle, out_full clears, ifm_sel_next toggles at the edge.
  - If a map completes in the same cycle that start_to_next fires, out_full stays 1 (set wins).
- Backpressure: while out_full = 1 the stage does not accept a new upstream start, so it never overwrites an unconsumed bank.

Test Plan:
- Single map, IFM_SIZE=9, ifm[a]=a, end_from_next=1: 16 writes; ofm[w]=(2r+1)*9+2c+1, e.g. ofm[0]=10, ofm[15]=70. First write in cycle 6, last in cycle 66; start_to_next pulses once; ifm_sel_next goes 0→1.
- Max position sweep: per window, put 0xFFFF_FFF0 at j=0, then 1, 2, 3, others 0 → output 0xFFFF_FFF0 in every case, proving an unsigned compare; all-equal windows of 5 → 5.
- Backpressure: end_from_next=0 after map 1; second start pulse → ignored, end_to_previous=0, no reads. Raise end_from_next → start_to_next pulse, end_to_previous returns to 1; next start is accepted.
- Start pulse during READ → ignored; ifm_sel_previous toggles once per accepted start only.
- 28 back-to-back maps → map_count wraps 27→0; ifm_sel_previous and ifm_sel_next each toggle 28 times.
- Reset asserted at read k=30 → all outputs at reset values the same cycle; no further writes; a fresh start produces a correct full map.

Source files
------------

// File: rtl/maxpool2_stage.sv
// 2x2 stride-2 max pooling stage between ping-pong map memories.
// Reads one upstream map window by window and writes one pooled value per window.
//
// state     | meaning
// IDLE      | waiting for an upstream start; accepts only when no unconsumed map is held
// READ      | issuing 4 reads per output window, one read per cycle
// DRAIN     | waiting for the final window write to retire
// WAIT_NEXT | one-cycle settle before returning to IDLE
module maxpool2_stage #(
    parameter int DATA_WIDTH        = 32,
    parameter int IFM_SIZE          = 9,
    parameter int NUMBER_OF_FILTERS = 28,
    parameter int OFM_SIZE          = IFM_SIZE / 2,
    parameter int ADDRESS_SIZE_IFM  = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_OFM  = $clog2(OFM_SIZE * OFM_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start_from_previous,
    output logic                                 end_to_previous,
    output logic                                 ifm_sel_previous,
    output logic                                 ifm_enable_read,
    output logic [ADDRESS_SIZE_IFM-1:0]          ifm_address_read,
    input  logic [DATA_WIDTH-1:0]                ifm_data_in,
    output logic                                 ofm_enable_write,
    output logic [ADDRESS_SIZE_OFM-1:0]          ofm_address_write,
    output logic [DATA_WIDTH-1:0]                ofm_data_out,
    output logic                                 ifm_sel_next,
    input  logic                                 end_from_next,
    output logic                                 start_to_next,
    output logic [$clog2(NUMBER_OF_FILTERS)-1:0] map_count
);
    localparam int MC_W    = $clog2(NUMBER_OF_FILTERS);
    localparam int NUM_WIN = OFM_SIZE * OFM_SIZE;
    localparam logic [ADDRESS_SIZE_OFM-1:0] LAST_W     = ADDRESS_SIZE_OFM'(NUM_WIN - 1);
    localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_COL   = ADDRESS_SIZE_IFM'(2 * (OFM_SIZE - 1));
    localparam logic [ADDRESS_SIZE_IFM-1:0] ROW_STEP   = ADDRESS_SIZE_IFM'(2 * IFM_SIZE);
    localparam logic [ADDRESS_SIZE_IFM-1:0] LINE       = ADDRESS_SIZE_IFM'(IFM_SIZE);
    localparam logic [MC_W-1:0]             LAST_MAP   = MC_W'(NUMBER_OF_FILTERS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT_NEXT} state_t;

    state_t state_q, state_d;

    logic [1:0]                  j_q;
    logic [ADDRESS_SIZE_OFM-1:0] w_q;
    logic [ADDRESS_SIZE_IFM-1:0] row_base_q, col_off_q, sub_off, rd_addr;
    logic                        d_valid_q, d_last_q, wr_last_q;
    logic [1:0]                  d_j_q;
    logic [ADDRESS_SIZE_OFM-1:0] d_w_q;
    logic [DATA_WIDTH-1:0]       max_q;
    logic                        out_full_q;
    logic                        accept, last_read, done;

    assign accept    = (state_q == IDLE) && !out_full_q && start_from_previous;
    assign last_read = (state_q == READ) && (j_q == 2'd3) && (w_q == LAST_W);
    assign done      = (state_q == DRAIN) && ofm_enable_write && wr_last_q;

    always_comb begin
        sub_off = '0;
        case (j_q)
            2'd0: sub_off = '0;
            2'd1: sub_off = ADDRESS_SIZE_IFM'(1);
            2'd2: sub_off = LINE;
            2'd3: sub_off = LINE + ADDRESS_SIZE_IFM'(1);
            default: sub_off = '0;
        endcase
    end
    assign rd_addr = row_base_q + col_off_q + sub_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept)    state_d = READ;
            READ:      if (last_read) state_d = DRAIN;
            DRAIN:     if (done)      state_d = WAIT_NEXT;
            WAIT_NEXT:                state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        end_to_previous  = (state_q == IDLE) && !out_full_q;
        ifm_enable_read  = (state_q == READ);
        ifm_address_read = (state_q == READ) ? rd_addr : '0;
    end

    // Window walk: j steps the 2x2 taps, col_off/row_base step 2 input pixels per window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j_q <= '0;  w_q <= '0;  row_base_q <= '0;  col_off_q <= '0;
            ifm_sel_previous <= 1'b0;
        end else if (accept) begin
            j_q <= '0;  w_q <= '0;  row_base_q <= '0;  col_off_q <= '0;
            ifm_sel_previous <= !ifm_sel_previous;
        end else if (state_q == READ) begin
            j_q <= j_q + 2'd1;
            if (j_q == 2'd3) begin
                w_q <= w_q + ADDRESS_SIZE_OFM'(1);
                if (col_off_q == LAST_COL) begin
                    col_off_q  <= '0;
                    row_base_q <= row_base_q + ROW_STEP;
                end else begin
                    col_off_q <= col_off_q + ADDRESS_SIZE_IFM'(2);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_valid_q <= 1'b0;  d_j_q <= '0;  d_w_q <= '0;  d_last_q <= 1'b0;
            max_q <= '0;  ofm_enable_write <= 1'b0;  ofm_address_write <= '0;  wr_last_q <= 1'b0;
        end else begin
            d_valid_q <= (state_q == READ);
            d_j_q     <= j_q;
            d_w_q     <= w_q;
            d_last_q  <= last_read;
            if (d_valid_q) begin
                if (d_j_q == 2'd0 || ifm_data_in > max_q) max_q <= ifm_data_in;
            end
            ofm_enable_write  <= d_valid_q && (d_j_q == 2'd3);
            ofm_address_write <= d_w_q;
            wr_last_q         <= d_valid_q && (d_j_q == 2'd3) && d_last_q;
        end
    end

    assign ofm_data_out  = max_q;
    assign start_to_next = out_full_q && end_from_next;

    // A completion in the same cycle as a handoff keeps the bank marked full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_full_q   <= 1'b0;
            map_count    <= '0;
            ifm_sel_next <= 1'b0;
        end else begin
            if (done)               out_full_q <= 1'b1;
            else if (start_to_next) out_full_q <= 1'b0;
            if (start_to_next) ifm_sel_next <= !ifm_sel_next;
            if (done) map_count <= (map_count == LAST_MAP) ? '0 : map_count + MC_W'(1);
        end
    end
endmodule

// File: tb/tb_maxpool2_stage.sv
// Directed bench for maxpool2_stage: upstream memory model with 1-cycle read latency,
// output capture by address, and per-scenario tasks with hand-computed expectations.
module tb_maxpool2_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_from_previous = 1'b0;
    logic        end_to_previous, ifm_sel_previous, ifm_enable_read;
    logic [6:0]  ifm_address_read;
    logic [31:0] ifm_data_in = '0;
    logic        ofm_enable_write;
    logic [3:0]  ofm_address_write;
    logic [31:0] ofm_data_out;
    logic        ifm_sel_next;
    logic        end_from_next = 1'b1;
    logic        start_to_next;
    logic [4:0]  map_count;

    maxpool2_stage dut (
        .clk(clk), .reset(reset), .start_from_previous(start_from_previous),
        .end_to_previous(end_to_previous), .ifm_sel_previous(ifm_sel_previous),
        .ifm_enable_read(ifm_enable_read), .ifm_address_read(ifm_address_read),
        .ifm_data_in(ifm_data_in), .ofm_enable_write(ofm_enable_write),
        .ofm_address_write(ofm_address_write), .ofm_data_out(ofm_data_out),
        .ifm_sel_next(ifm_sel_next), .end_from_next(end_from_next),
        .start_to_next(start_to_next), .map_count(map_count)
    );

    always #5 clk = !clk;

    logic [31:0] ifm_mem [81];
    logic [31:0] ofm_cap [16];
    int n_cmp = 0, n_bad = 0;
    int edge_cnt = 0, accept_edge = 0, first_wr_edge = 0, last_wr_edge = 0;
    int rd_cnt = 0, wr_cnt = 0, stn_cnt = 0, tog_sp = 0, tog_sn = 0;
    logic prev_sp = 1'b0, prev_sn = 1'b0;

    always @(posedge clk) begin
        if (ifm_enable_read) ifm_data_in <= ifm_mem[ifm_address_read];
    end

    always @(posedge clk) begin
        edge_cnt++;
        if (!reset && start_from_previous && end_to_previous) accept_edge = edge_cnt;
        if (ifm_enable_read) rd_cnt++;
        if (start_to_next) stn_cnt++;
        if (ofm_enable_write) begin
            ofm_cap[ofm_address_write] = ofm_data_out;
            wr_cnt++;
            if (ofm_address_write == 4'd0)  first_wr_edge = edge_cnt;
            if (ofm_address_write == 4'd15) last_wr_edge = edge_cnt;
        end
        if (ifm_sel_previous !== prev_sp) tog_sp++;
        if (ifm_sel_next !== prev_sn) tog_sn++;
        prev_sp = ifm_sel_previous;
        prev_sn = ifm_sel_next;
    end

    function automatic int exp_addr(input int w, input int j);
        int r = w / 4;
        int c = w % 4;
        int off = (j == 0) ? 0 : (j == 1) ? 1 : (j == 2) ? 9 : 10;
        return 2 * r * 9 + 2 * c + off;
    endfunction

    task automatic clear_cap;
        for (int i = 0; i < 16; i++) ofm_cap[i] = 32'hDEAD_BEEF;
    endtask

    task automatic pulse_start;
        @(negedge clk); start_from_previous = 1'b1;
        @(negedge clk); start_from_previous = 1'b0;
    endtask

    task automatic wait_writes(input int target, output bit ok);
        int t = 0;
        while (wr_cnt < target && t < 400) begin
            @(negedge clk); t++;
        end
        ok = (wr_cnt >= target);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (end_to_previous !== 1'b1) begin
            n_bad++; $display("FAIL reset_end_to_previous got %b want 1", end_to_previous);
        end
        n_cmp++;
        if ({ifm_enable_read, ofm_enable_write, start_to_next, ifm_sel_previous, ifm_sel_next,
             map_count, ifm_address_read, ofm_address_write, ofm_data_out} !== '0) begin
            n_bad++; $display("FAIL reset_outputs got %h want 0", {ifm_enable_read, ofm_enable_write,
                start_to_next, ifm_sel_previous, ifm_sel_next, map_count, ifm_address_read,
                ofm_address_write, ofm_data_out});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_map;
        bit ok;
        int wr0 = wr_cnt, stn0 = stn_cnt;
        for (int a = 0; a < 81; a++) ifm_mem[a] = 32'(a);
        end_from_next = 1'b1;
        clear_cap();
        pulse_start();
        wait_writes(wr0 + 16, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_timeout writes %0d want 16", wr_cnt - wr0); end
        for (int w = 0; w < 16; w++) begin
            n_cmp++;
            if (ofm_cap[w] !== 32'((2 * (w / 4) + 1) * 9 + 2 * (w % 4) + 1)) begin
                n_bad++; $display("FAIL single_ofm[%0d] got %0d want %0d", w, ofm_cap[w],
                                  (2 * (w / 4) + 1) * 9 + 2 * (w % 4) + 1);
            end
        end
        n_cmp++;
        if (first_wr_edge - accept_edge !== 6) begin
            n_bad++; $display("FAIL first_write_cycle got %0d want 6", first_wr_edge - accept_edge);
        end
        n_cmp++;
        if (last_wr_edge - accept_edge !== 66) begin
            n_bad++; $display("FAIL last_write_cycle got %0d want 66", last_wr_edge - accept_edge);
        end
        n_cmp++;
        if (stn_cnt - stn0 !== 1) begin
            n_bad++; $display("FAIL single_start_to_next got %0d pulses want 1", stn_cnt - stn0);
        end
        n_cmp++;
        if ({ifm_sel_previous, ifm_sel_next, map_count, end_to_previous} !== {1'b1, 1'b1, 5'd1, 1'b1}) begin
            n_bad++; $display("FAIL single_status got sp=%b sn=%b mc=%0d etp=%b want 1 1 1 1",
                              ifm_sel_previous, ifm_sel_next, map_count, end_to_previous);
        end
    endtask

    task automatic test_max_sweep;
        bit ok;
        logic [31:0] want;
        for (int pos = 0; pos < 5; pos++) begin
            for (int a = 0; a < 81; a++) ifm_mem[a] = (pos == 4) ? 32'd5 : 32'd0;
            if (pos < 4) for (int w = 0; w < 16; w++) ifm_mem[exp_addr(w, pos)] = 32'hFFFF_FFF0;
            want = (pos == 4) ? 32'd5 : 32'hFFFF_FFF0;
            clear_cap();
            pulse_start();
            wait_writes(wr_cnt + 16, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL sweep_timeout pos=%0d", pos); end
            for (int w = 0; w < 16; w++) begin
                n_cmp++;
                if (ofm_cap[w] !== want) begin
                    n_bad++; $display("FAIL sweep pos=%0d ofm[%0d] got %h want %h", pos, w, ofm_cap[w], want);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int rd0;
        logic sp0;
        for (int a = 0; a < 81; a++) ifm_mem[a] = 32'(a);
        end_from_next = 1'b0;
        pulse_start();
        wait_writes(wr_cnt + 16, ok);
        n_cmp++;
        if (!ok || end_to_previous !== 1'b0) begin
            n_bad++; $display("FAIL bp_held ok=%b end_to_previous got %b want 0", ok, end_to_previous);
        end
        rd0 = rd_cnt; sp0 = ifm_sel_previous;
        pulse_start();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (rd_cnt !== rd0 || ifm_sel_previous !== sp0 || end_to_previous !== 1'b0) begin
            n_bad++; $display("FAIL bp_ignored reads got %0d want 0 sel got %b want %b etp %b want 0",
                              rd_cnt - rd0, ifm_sel_previous, sp0, end_to_previous);
        end
        end_from_next = 1'b1;
        #1;
        n_cmp++;
        if (start_to_next !== 1'b1) begin
            n_bad++; $display("FAIL bp_release start_to_next got %b want 1", start_to_next);
        end
        @(negedge clk);
        n_cmp++;
        if (start_to_next !== 1'b0 || end_to_previous !== 1'b1) begin
            n_bad++; $display("FAIL bp_after start_to_next got %b want 0 etp got %b want 1",
                              start_to_next, end_to_previous);
        end
        rd0 = rd_cnt;
        pulse_start();
        wait_writes(wr_cnt + 16, ok);
        n_cmp++;
        if (!ok || rd_cnt - rd0 !== 64) begin
            n_bad++; $display("FAIL bp_next_map ok=%b reads got %0d want 64", ok, rd_cnt - rd0);
        end
    endtask

    task automatic test_start_during_read;
        bit ok;
        int rd0 = rd_cnt, wr0 = wr_cnt;
        logic sp0 = ifm_sel_previous;
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        wait_writes(wr0 + 16, ok);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (!ok || rd_cnt - rd0 !== 64 || wr_cnt - wr0 !== 16) begin
            n_bad++; $display("FAIL sdr_counts ok=%b reads got %0d want 64 writes got %0d want 16",
                              ok, rd_cnt - rd0, wr_cnt - wr0);
        end
        n_cmp++;
        if (ifm_sel_previous !== !sp0) begin
            n_bad++; $display("FAIL sdr_sel_previous got %b want %b", ifm_sel_previous, !sp0);
        end
    endtask

    task automatic test_reset_mid_map;
        bit ok;
        int wr0;
        for (int a = 0; a < 81; a++) ifm_mem[a] = 32'(a);
        end_from_next = 1'b1;
        @(negedge clk); start_from_previous = 1'b1;
        @(negedge clk); start_from_previous = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (ifm_enable_read !== 1'b1 || ifm_address_read !== 7'd33) begin
            n_bad++; $display("FAIL mid_read_k30 en got %b addr got %0d want 1 33", ifm_enable_read, ifm_address_read);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (end_to_previous !== 1'b1 ||
            {ifm_enable_read, ofm_enable_write, start_to_next, ifm_sel_previous, ifm_sel_next,
             map_count, ifm_address_read, ofm_address_write, ofm_data_out} !== '0) begin
            n_bad++; $display("FAIL mid_reset_outputs etp=%b rest=%h want 1 0", end_to_previous,
                {ifm_enable_read, ofm_enable_write, start_to_next, ifm_sel_previous, ifm_sel_next,
                 map_count, ifm_address_read, ofm_address_write, ofm_data_out});
        end
        wr0 = wr_cnt;
        @(negedge clk); reset = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (wr_cnt !== wr0) begin
            n_bad++; $display("FAIL mid_no_writes got %0d want 0", wr_cnt - wr0);
        end
        clear_cap();
        pulse_start();
        wait_writes(wr0 + 16, ok);
        n_cmp++;
        if (!ok || map_count !== 5'd1) begin
            n_bad++; $display("FAIL mid_fresh ok=%b map_count got %0d want 1", ok, map_count);
        end
        for (int w = 0; w < 16; w++) begin
            n_cmp++;
            if (ofm_cap[w] !== 32'(exp_addr(w, 3))) begin
                n_bad++; $display("FAIL mid_ofm[%0d] got %0d want %0d", w, ofm_cap[w], exp_addr(w, 3));
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int t, wr0, tsp0, tsn0, stn0;
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        wr0 = wr_cnt; tsp0 = tog_sp; tsn0 = tog_sn; stn0 = stn_cnt;
        for (int m = 0; m < 28; m++) begin
            t = 0;
            while (end_to_previous !== 1'b1 && t < 200) begin @(negedge clk); t++; end
            start_from_previous = 1'b1;
            @(negedge clk); start_from_previous = 1'b0;
            t = 0;
            while (wr_cnt < wr0 + 16 * (m + 1) && t < 200) begin @(negedge clk); t++; end
            if (m == 26) begin
                n_cmp++;
                if (map_count !== 5'd27) begin
                    n_bad++; $display("FAIL b2b_count27 got %0d want 27", map_count);
                end
            end
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (map_count !== 5'd0 || wr_cnt - wr0 !== 448) begin
            n_bad++; $display("FAIL b2b_wrap map_count got %0d want 0 writes got %0d want 448",
                              map_count, wr_cnt - wr0);
        end
        n_cmp++;
        if (tog_sp - tsp0 !== 28 || tog_sn - tsn0 !== 28 || stn_cnt - stn0 !== 28) begin
            n_bad++; $display("FAIL b2b_toggles sp got %0d sn got %0d stn got %0d want 28 28 28",
                              tog_sp - tsp0, tog_sn - tsn0, stn_cnt - stn0);
        end
    endtask

    initial begin
        for (int a = 0; a < 81; a++) ifm_mem[a] = '0;
        clear_cap();
        test_reset();
        test_single_map();
        test_max_sweep();
        test_backpressure();
        test_start_during_read();
        test_reset_mid_map();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
